// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Serves one operation at a time through IDLE -> EXEC -> RESP, alternating
// priority between requesters when both are valid.
module alu_arbiter #(
    parameter int unsigned N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [5:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [5:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [5:0]   alu_op,
    input  logic [N-1:0] alu_result
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         prio_q;
    logic [N-1:0] a_q, b_q;
    logic [5:0]   op_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic [N-1:0] rsp_data_q;
    logic         rsp_id_q;
    logic         rsp_err_q;

    logic         gnt_any;
    logic         gnt_id;
    logic         hs;
    logic         op_legal;

    // Grant selection: sole valid requester wins, ties broken by prio_q.
    always_comb begin
        gnt_any    = req0_valid | req1_valid;
        gnt_id     = (req0_valid & req1_valid) ? prio_q : req1_valid;
        req0_ready = (state_q == StIdle) & ~rst & gnt_any & ~gnt_id;
        req1_ready = (state_q == StIdle) & ~rst & gnt_any & gnt_id;
        hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    // Decode the latched opcode against the set the ALU implements.
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b000011, 6'b000010, 6'b100111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (hs) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, operand latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                a_q    <= gnt_id ? req1_a : req0_a;
                b_q    <= gnt_id ? req1_b : req0_b;
                op_q   <= gnt_id ? req1_op : req0_op;
                id_q   <= gnt_id;
                prio_q <= ~gnt_id;
            end
            if (state_q == StExec) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= alu_result;
                rsp_id_q    <= id_q;
                rsp_err_q   <= ~op_legal;
            end
            // Response handshake only counts while a response is held.
            if ((state_q == StResp) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // The shared ALU always sees the latched operation.
    always_comb begin
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner-case
// sequences and randomized traffic checked by a transaction-level monitor.
module tb_alu_arbiter;

    localparam int N = 7;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_id, rsp_err;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [5:0]   alu_op;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU; illegal opcodes return zero.
    function automatic logic [N-1:0] alu_model(logic [N-1:0] a, logic [N-1:0] b,
                                               logic [5:0] op);
        logic signed [N-1:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return sa >>> b;
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return '0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b100110, 6'b000011, 6'b000010, 6'b100111};
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [8];
        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b000011, 6'b000010, 6'b100111};
        if (($urandom % 4) != 0) return ops[$urandom % 8];
        return 6'($urandom);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level monitor ----------------
    typedef struct {
        logic [N-1:0] data;
        bit           id;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    bit   served[$];
    bit   busy   = 1'b0;
    bit   prio_m = 1'b0;
    int   cyc    = 0;
    int   hs_cyc = 0;

    always @(negedge clk) begin
        bit   e0, e1, ev, sid;
        exp_t t;
        cyc++;
        if (rst) begin
            chk("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
            busy   = 1'b0;
            prio_m = 1'b0;
            exp_q.delete();
        end else begin
            e0 = !busy && req0_valid && (!req1_valid || prio_m == 1'b0);
            e1 = !busy && req1_valid && (!req0_valid || prio_m == 1'b1);
            chk("grant", {30'd0, req0_ready, req1_ready}, {30'd0, e0, e1});
            ev = busy && (cyc - hs_cyc >= 2);
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
            if (rsp_valid && ev && exp_q.size() > 0) begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                sid    = req1_valid && req1_ready;
                t.id   = sid;
                t.data = sid ? alu_model(req1_a, req1_b, req1_op)
                             : alu_model(req0_a, req0_b, req0_op);
                t.err  = sid ? !is_legal(req1_op) : !is_legal(req0_op);
                exp_q.push_back(t);
                served.push_back(sid);
                busy   = 1'b1;
                hs_cyc = cyc;
                prio_m = !sid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = N'($urandom); req0_b = N'($urandom); req0_op = 6'($urandom);
        req1_a = N'($urandom); req1_b = N'($urandom); req1_op = 6'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic do_txn(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [5:0] op, output logic [N-1:0] d, output bit rid,
                          output bit err, output int lat);
        bit got;
        @(posedge clk); #2;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            if (got) break;
        end
        lat = -1;
        d   = '0;
        rid = 1'b0;
        err = 1'b0;
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #2;
            idle_inputs();
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    lat = i;
                    break;
                end
            end
            d   = rsp_data;
            rid = rsp_id;
            err = rsp_err;
        end
    endtask

    typedef struct {
        bit           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [5:0]   op;
        logic [N-1:0] exp_d;
        bit           exp_err;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [11];
        logic [N-1:0] d;
        bit           rid, err, ok;
        int           lat;

        vecs[0]  = '{1'b0, 7'd5,    7'd3,    6'b100000, 7'd8,    1'b0};
        vecs[1]  = '{1'b1, 7'd5,    7'd3,    6'b111111, 7'd0,    1'b1};
        vecs[2]  = '{1'b0, 7'd3,    7'd5,    6'b100010, 7'h7E,   1'b0};
        vecs[3]  = '{1'b0, 7'h42,   7'd1,    6'b000011, 7'h61,   1'b0};
        vecs[4]  = '{1'b0, 7'h42,   7'd1,    6'b000010, 7'h21,   1'b0};
        vecs[5]  = '{1'b1, 7'h5A,   7'h33,   6'b100100, 7'h12,   1'b0};
        vecs[6]  = '{1'b1, 7'h5A,   7'h33,   6'b100101, 7'h7B,   1'b0};
        vecs[7]  = '{1'b0, 7'h5A,   7'h33,   6'b100110, 7'h69,   1'b0};
        vecs[8]  = '{1'b1, 7'h5A,   7'h33,   6'b100111, 7'h04,   1'b0};
        vecs[9]  = '{1'b0, 7'h7F,   7'h01,   6'b100000, 7'h00,   1'b0};
        vecs[10] = '{1'b1, 7'h42,   7'd1,    6'b000001, 7'h00,   1'b1};

        rst = 1'b1;
        rsp_ready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id_err", {30'd0, rsp_id, rsp_err}, 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            do_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, d, rid, err, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_id", i), {31'd0, rid}, {31'd0, vecs[i].id});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // Both requesters valid continuously: strict alternation from req0.
        do_reset(1);
        served.delete();
        req0_valid = 1'b1; req0_a = 7'd1; req0_b = 7'd2; req0_op = 6'b100000;
        req1_valid = 1'b1; req1_a = 7'd9; req1_b = 7'd4; req1_op = 6'b100010;
        for (int i = 0; i < 40 && served.size() < 4; i++) @(posedge clk);
        #2 idle_inputs();
        chk("alt_count", served.size() >= 4 ? 32'd1 : 32'd0, 32'd1);
        if (served.size() >= 4) begin
            chk("alt_order", {28'd0, served[0], served[1], served[2], served[3]}, 32'b0101);
        end
        repeat (6) @(posedge clk);

        // Response held for five cycles with another requester waiting.
        rsp_ready = 1'b0;
        do_txn(1'b0, 7'd1, 7'd2, 6'b100000, d, rid, err, lat);
        chk("hold_latency", 32'(lat), 32'd2);
        #2 req1_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data != 7'd3 || req0_ready || req1_ready) ok = 1'b0;
        end
        chk("hold_stable", {31'd0, ok}, 32'd1);
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2 idle_inputs();
        repeat (6) @(posedge clk);

        // Reset pulsed during EXEC discards the transaction and clears prio.
        @(posedge clk); #2;
        req0_valid = 1'b1; req0_a = 7'd7; req0_b = 7'd7; req0_op = 6'b100000;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_exec_grant", {31'd0, ok}, 32'd1);
        @(posedge clk); #2;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b0;
        end
        chk("rst_exec_no_rsp", {31'd0, ok}, 32'd1);
        chk("rst_exec_alu_a", 32'(alu_a), 32'd0);
        @(posedge clk); #2;
        req0_valid = 1'b1; req0_a = 7'd2; req0_b = 7'd2; req0_op = 6'b100000;
        req1_valid = 1'b1; req1_a = 7'd1; req1_b = 7'd1; req1_op = 6'b100000;
        @(negedge clk);
        chk("rst_exec_prio", {30'd0, req0_ready, req1_ready}, 32'b10);
        @(posedge clk); #2;
        idle_inputs();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk("rst_exec_next_data", 32'(rsp_data), 32'd4);
        chk("rst_exec_next_id", {31'd0, rsp_id}, 32'd0);
        repeat (3) @(posedge clk);

        // Randomized traffic, checked by the monitor.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            rst        = (($urandom % 100) == 0);
            req0_valid = (($urandom % 10) < 6);
            req1_valid = (($urandom % 10) < 6);
            req0_a = N'($urandom); req0_b = N'($urandom % 8); req0_op = pick_op();
            req1_a = N'($urandom); req1_b = N'($urandom % 8); req1_op = pick_op();
            rsp_ready  = (($urandom % 10) < 7);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        idle_inputs();
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 7, data width of operands and result (matches ALU width).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqX_valid  input  1  requester X (X=0,1) presents an operation.
REQ-005 reqX_ready  output  1  arbiter accepts requester X this cycle.
REQ-006 reqX_a  input  N  requester X operand A (treated as signed by ALU).
REQ-007 reqX_b  input  N  requester X operand B.
REQ-008 reqX_op  input  6  requester X ALU opcode.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumer accepts response.
REQ-011 rsp_data  output  N  ALU result of served request.
REQ-012 rsp_id  output  1  index of served requester.
REQ-013 rsp_err  output  1  served opcode was not a legal ALU opcode.
REQ-014 alu_a / alu_b  output  N  operands driven to shared ALU.
REQ-015 alu_op  output  6  opcode driven to shared ALU.
REQ-016 alu_result  input  N  combinational result returned by shared ALU.

Function
REQ-017 The block SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-018 In IDLE, grant SHALL go to the sole valid requester; if both valid, to the requester selected by priority bit prio (0 -> req0).
REQ-019 reqX_ready SHALL be high only in IDLE, only for the granted requester, and only when rst is low; it SHALL be low in EXEC and RESP.
REQ-020 On handshake (reqX_valid & reqX_ready) the block SHALL latch a, b, op, id into internal registers, set prio to the non-granted index, and enter EXEC.
REQ-021 alu_a, alu_b, alu_op SHALL always be driven directly from the latched registers.
REQ-022 EXEC SHALL last exactly one cycle; at its end rsp_data <= alu_result, rsp_err <= (op not in legal set), rsp_valid <= 1, state <= RESP.
REQ-023 Legal set: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000011 sra, 000010 srl, 100111 nor.
REQ-024 rsp_data SHALL equal alu_result unmodified (N bits, wrap-around on overflow, no saturation).
REQ-025 Latency: handshake at edge k -> rsp_valid high in the cycle after edge k+2's predecessor, i.e. from edge k+2 onward (2 cycles).
REQ-026 In RESP, rsp_valid, rsp_data, rsp_id, rsp_err SHALL remain stable until rsp_ready is sampled high; on that edge rsp_valid <= 0 and state <= IDLE.
REQ-027 New grant SHALL NOT occur in the same cycle as response handshake; minimum 3 cycles per transaction.
REQ-028 rsp_ready while rsp_valid low SHALL be ignored.
REQ-029 A requester deasserting valid before handshake SHALL leave state, prio and outputs unchanged.
REQ-030 Operand inputs SHALL be ignored outside the handshake cycle.

Reset
REQ-031 While rst is high at an edge: state <= IDLE, prio <= 0, rsp_valid/rsp_data/rsp_id/rsp_err <= 0, latched a/b/op/id <= 0 (so alu_a/alu_b/alu_op = 0).
REQ-032 Reset in EXEC or RESP SHALL discard the in-flight transaction; no response for it SHALL ever be emitted.

Verification
REQ-033 Reset, req0 add a=5 b=3 -> rsp_valid 2 cycles after handshake, rsp_data=8, rsp_id=0, rsp_err=0.
REQ-034 After reset both valid continuously, rsp_ready=1 -> service order req0, req1, req0, req1; reqX_ready never high for both at once.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable, req0_ready and req1_ready low throughout.
REQ-036 req1 op=111111 -> rsp_data=0, rsp_err=1, rsp_id=1.
REQ-037 N=7: sub a=3 b=5 -> rsp_data=7'h7E; sra a=7'b1000010 -> 7'b1100001; srl same a -> 7'b0100001.
REQ-038 rst pulsed one cycle during EXEC -> rsp_valid stays 0, state IDLE, prio 0, next request served normally.
